// File: rtl/cpu_pkg.sv
// Shared types and defaults for the program-counter sequencer.
package cpu_pkg;

    localparam int unsigned PC_WIDTH_DEFAULT = 64;
    localparam int unsigned PC_STEP_DEFAULT  = 4;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StExec,
        StUpdate,
        StHalt
    } seq_state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the PC sequencer and the CPU datapath/fetch unit.
interface pc_sequencer_if
    import cpu_pkg::*;
#(
    parameter int unsigned PC_WIDTH = PC_WIDTH_DEFAULT
);
    logic                Run;
    logic                Halt;
    logic                FetchAck;
    logic                ExecDone;
    logic                Branch;
    logic                Uncond;
    logic                Zero;
    logic [PC_WIDTH-1:0] BranchOffset;
    logic [PC_WIDTH-1:0] PCOut;
    logic                FetchReq;
    logic [31:0]         count;
    logic                Halted;
    logic                Fault;

    modport master (
        input  Run, Halt, FetchAck, ExecDone, Branch, Uncond, Zero, BranchOffset,
        output PCOut, FetchReq, count, Halted, Fault
    );

    modport slave (
        output Run, Halt, FetchAck, ExecDone, Branch, Uncond, Zero, BranchOffset,
        input  PCOut, FetchReq, count, Halted, Fault
    );
endinterface

// File: rtl/pc_next_calc.sv
// Combinational next-PC: taken branch adds the word offset, otherwise step sequentially.
module pc_next_calc
    import cpu_pkg::*;
#(
    parameter int unsigned PC_WIDTH = PC_WIDTH_DEFAULT,
    parameter int unsigned PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic [PC_WIDTH-1:0] i_pc,
    input  logic [PC_WIDTH-1:0] i_offset,
    input  logic                i_branch,
    input  logic                i_uncond,
    input  logic                i_zero,
    output logic [PC_WIDTH-1:0] o_next_pc
);
    logic w_taken;

    // Uncond alone suffices, so it naturally dominates Branch.
    assign w_taken   = i_uncond | (i_branch & i_zero);
    assign o_next_pc = w_taken ? (i_pc + (i_offset << 2)) : (i_pc + PC_WIDTH'(PC_STEP));
endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute/update sequencer: owns the PC, retired count, and halt/fault state.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned          PC_WIDTH    = PC_WIDTH_DEFAULT,
    parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0,
    parameter int unsigned          PC_STEP     = PC_STEP_DEFAULT,
    parameter int unsigned          ACK_TIMEOUT = 16
) (
    input logic            Clock,
    input logic            Reset_n,
    pc_sequencer_if.master bus
);
    seq_state_t          r_state;
    seq_state_t          w_state_next;
    logic [PC_WIDTH-1:0] r_pc;
    logic [31:0]         r_count;
    logic                r_fault;
    logic [7:0]          r_tmo;
    logic [8:0]          w_tmo_inc;
    logic                w_tmo_expired;
    logic                w_fault_set;
    logic                r_branch;
    logic                r_uncond;
    logic                r_zero;
    logic [PC_WIDTH-1:0] r_offset;
    logic [PC_WIDTH-1:0] w_next_pc;

    pc_next_calc #(
        .PC_WIDTH (PC_WIDTH),
        .PC_STEP  (PC_STEP)
    ) u_next (
        .i_pc      (r_pc),
        .i_offset  (r_offset),
        .i_branch  (r_branch),
        .i_uncond  (r_uncond),
        .i_zero    (r_zero),
        .o_next_pc (w_next_pc)
    );

    assign w_tmo_inc     = {1'b0, r_tmo} + 9'd1;
    assign w_tmo_expired = (w_tmo_inc == 9'(ACK_TIMEOUT));

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Halt has priority everywhere; in UPDATE the datapath writes still happen.
    always_comb begin
        w_state_next = r_state;
        w_fault_set  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.Halt) w_state_next = StHalt;
                else if (bus.Run) w_state_next = StFetch;
            end
            StFetch: begin
                if (bus.Halt) begin
                    w_state_next = StHalt;
                end else if (bus.FetchAck) begin
                    w_state_next = StExec;
                end else if (w_tmo_expired) begin
                    w_state_next = StHalt;
                    w_fault_set  = 1'b1;
                end
            end
            StExec: begin
                if (bus.Halt) w_state_next = StHalt;
                else if (bus.ExecDone) w_state_next = StUpdate;
            end
            StUpdate: begin
                if (bus.Halt) w_state_next = StHalt;
                else if (bus.Run) w_state_next = StFetch;
                else w_state_next = StIdle;
            end
            StHalt: w_state_next = StHalt;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            r_pc     <= RESET_PC;
            r_count  <= '0;
            r_fault  <= 1'b0;
            r_tmo    <= '0;
            r_branch <= 1'b0;
            r_uncond <= 1'b0;
            r_zero   <= 1'b0;
            r_offset <= '0;
        end else begin
            if (r_state == StFetch) begin
                r_tmo <= bus.FetchAck ? 8'd0 : w_tmo_inc[7:0];
            end
            if (w_fault_set) begin
                r_fault <= 1'b1;
            end
            if ((r_state == StExec) && bus.ExecDone) begin
                r_branch <= bus.Branch;
                r_uncond <= bus.Uncond;
                r_zero   <= bus.Zero;
                r_offset <= bus.BranchOffset;
            end
            if (r_state == StUpdate) begin
                r_pc    <= w_next_pc;
                r_count <= r_count + 32'd1;
            end
        end
    end

    assign bus.PCOut    = r_pc;
    assign bus.FetchReq = (r_state == StFetch);
    assign bus.Halted   = (r_state == StHalt);
    assign bus.Fault    = r_fault;
    assign bus.count    = r_count;
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed corner cases plus randomized instruction streams.
module tb_pc_sequencer;
    import cpu_pkg::*;

    localparam int unsigned ACK_TO = 16;

    typedef struct {
        longint unsigned pc;
        int unsigned     cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pc_sequencer_if #(.PC_WIDTH(64)) bus ();

    pc_sequencer #(
        .PC_WIDTH    (64),
        .RESET_PC    (64'h0),
        .PC_STEP     (4),
        .ACK_TIMEOUT (ACK_TO)
    ) dut (
        .Clock   (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    exp_t            exp_q[$];
    exp_t            mon_e;
    int              checks = 0;
    int              errors = 0;
    int              cyc = 0;
    longint unsigned m_pc = 0;
    int unsigned     m_cnt = 0;
    longint unsigned mon_pc = 0;
    logic [31:0]     mon_prev = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every retirement pops one expected record; every fetch must present the model PC.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_pc   = 64'h0;
            mon_prev = '0;
        end else begin
            if (bus.count !== mon_prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL retire_unexpected: count=%0d pc=%h, nothing expected",
                             bus.count, bus.PCOut);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (bus.PCOut !== mon_e.pc || bus.count !== mon_e.cnt) begin
                        errors++;
                        $display("FAIL retire: got pc=%h count=%0d, required pc=%h count=%0d",
                                 bus.PCOut, bus.count, mon_e.pc, mon_e.cnt);
                    end
                    mon_pc = mon_e.pc;
                end
            end
            if (bus.FetchReq === 1'b1) begin
                checks++;
                if (bus.PCOut !== mon_pc) begin
                    errors++;
                    $display("FAIL fetch_pc: got %h, required %h", bus.PCOut, mon_pc);
                end
            end
            mon_prev = bus.count;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic clear_inputs();
        bus.Run          = 1'b0;
        bus.Halt         = 1'b0;
        bus.FetchAck     = 1'b0;
        bus.ExecDone     = 1'b0;
        bus.Branch       = 1'b0;
        bus.Uncond       = 1'b0;
        bus.Zero         = 1'b0;
        bus.BranchOffset = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        exp_q.delete();
        m_pc  = 0;
        m_cnt = 0;
        check("reset_pc", bus.PCOut, 64'h0);
        check("reset_count", 64'(bus.count), 64'h0);
        check("reset_fetchreq", 64'(bus.FetchReq), 64'h0);
        check("reset_halted", 64'(bus.Halted), 64'h0);
        check("reset_fault", 64'(bus.Fault), 64'h0);
        rst_n = 1'b1;
    endtask

    task automatic wait_fetch(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.FetchReq === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL fetch_wait: FetchReq=0 after 40 cycles, required 1");
        end
    endtask

    // One instruction; returns at the negedge inside the UPDATE cycle.
    task automatic run_instr(input int d, input int e, input bit br, input bit un, input bit z,
                             input logic [63:0] off);
        bit   ok;
        exp_t item;
        wait_fetch(ok);
        if (!ok) return;
        for (int i = 0; i < d; i++) begin
            bus.FetchAck = 1'b0;
            bus.ExecDone = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        bus.FetchAck = 1'b1;
        bus.ExecDone = 1'b0;
        @(negedge clk);
        for (int i = 0; i < e; i++) begin
            bus.FetchAck     = 1'($urandom_range(0, 1));
            bus.Branch       = 1'($urandom_range(0, 1));
            bus.Uncond       = 1'($urandom_range(0, 1));
            bus.Zero         = 1'($urandom_range(0, 1));
            bus.BranchOffset = {$urandom, $urandom};
            @(negedge clk);
        end
        bus.FetchAck     = 1'b0;
        bus.ExecDone     = 1'b1;
        bus.Branch       = br;
        bus.Uncond       = un;
        bus.Zero         = z;
        bus.BranchOffset = off;
        if (un || (br && z)) m_pc = m_pc + off * 64'd4;
        else m_pc = m_pc + 64'd4;
        m_cnt++;
        item.pc  = m_pc;
        item.cnt = m_cnt;
        exp_q.push_back(item);
        @(negedge clk);
        bus.ExecDone     = 1'b0;
        bus.Branch       = 1'($urandom_range(0, 1));
        bus.Uncond       = 1'($urandom_range(0, 1));
        bus.Zero         = 1'($urandom_range(0, 1));
        bus.BranchOffset = {$urandom, $urandom};
    endtask

    task automatic instr_chk(input string name, input bit br, input bit un, input bit z,
                             input logic [63:0] off, input logic [63:0] want_pc);
        run_instr(0, 0, br, un, z, off);
        @(negedge clk);
        check(name, bus.PCOut, want_pc);
    endtask

    task automatic seq_n(input int n);
        for (int i = 0; i < n; i++) begin
            run_instr($urandom_range(0, 2), $urandom_range(0, 2), 1'b0, 1'b0, 1'b0, 64'h0);
        end
    endtask

    initial begin
        int   prev_cyc;
        int   nreq;
        bit   ok;
        int   s;
        logic [63:0] off;

        clear_inputs();

        // Back-to-back sequential instructions at the minimum 3-cycle rate.
        do_reset();
        bus.Run = 1'b1;
        run_instr(0, 0, 1'b0, 1'b0, 1'b0, 64'h0);
        prev_cyc = cyc;
        for (int i = 0; i < 3; i++) begin
            run_instr(0, 0, 1'b0, 1'b0, 1'b0, 64'h0);
            check("cycles_per_instr", 64'(cyc - prev_cyc), 64'd3);
            prev_cyc = cyc;
        end
        @(negedge clk);
        check("pc_after4", bus.PCOut, 64'd16);
        check("count_after4", 64'(bus.count), 64'd4);

        // Conditional branch taken / not taken from PC=8.
        do_reset();
        bus.Run = 1'b1;
        seq_n(2);
        instr_chk("cbz_taken", 1'b1, 1'b0, 1'b1, -64'sd2, 64'h0);
        seq_n(2);
        instr_chk("cbz_not_taken", 1'b1, 1'b0, 1'b0, -64'sd2, 64'd12);

        // Uncond priority, backward wrap, sequential wrap, self-loop.
        do_reset();
        bus.Run = 1'b1;
        instr_chk("uncond_and_branch", 1'b1, 1'b1, 1'b0, 64'd5, 64'd20);
        instr_chk("branch_to_top", 1'b0, 1'b1, 1'b0, -64'sd6, 64'hFFFF_FFFF_FFFF_FFFC);
        instr_chk("seq_wrap", 1'b0, 1'b0, 1'b0, 64'd0, 64'h0);
        instr_chk("self_loop", 1'b0, 1'b1, 1'b0, 64'd0, 64'h0);

        // Fetch timeout.
        do_reset();
        bus.Run = 1'b1;
        wait_fetch(ok);
        nreq = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.FetchReq !== 1'b1) break;
            nreq++;
        end
        check("timeout_req_cycles", 64'(nreq), 64'(ACK_TO));
        check("timeout_halted", 64'(bus.Halted), 64'h1);
        check("timeout_fault", 64'(bus.Fault), 64'h1);
        check("timeout_fetchreq", 64'(bus.FetchReq), 64'h0);
        bus.FetchAck = 1'b1;
        repeat (4) @(negedge clk);
        check("timeout_sticky_halted", 64'(bus.Halted), 64'h1);
        check("timeout_sticky_fault", 64'(bus.Fault), 64'h1);
        bus.FetchAck = 1'b0;

        // Halt in EXEC: nothing retires.
        do_reset();
        bus.Run = 1'b1;
        seq_n(3);
        wait_fetch(ok);
        bus.FetchAck = 1'b1;
        @(negedge clk);
        bus.FetchAck = 1'b0;
        bus.Halt     = 1'b1;
        @(negedge clk);
        check("halt_exec_halted", 64'(bus.Halted), 64'h1);
        check("halt_exec_count", 64'(bus.count), 64'd3);
        check("halt_exec_pc", bus.PCOut, 64'd12);
        check("halt_exec_fault", 64'(bus.Fault), 64'h0);
        check("halt_exec_fetchreq", 64'(bus.FetchReq), 64'h0);

        // Halt in UPDATE: the update completes first.
        do_reset();
        bus.Run = 1'b1;
        seq_n(2);
        run_instr(0, 0, 1'b0, 1'b0, 1'b0, 64'h0);
        bus.Halt = 1'b1;
        @(negedge clk);
        check("halt_update_count", 64'(bus.count), 64'd3);
        check("halt_update_pc", bus.PCOut, 64'd12);
        check("halt_update_halted", 64'(bus.Halted), 64'h1);

        // Reset mid-EXEC.
        do_reset();
        bus.Run = 1'b1;
        seq_n(7);
        wait_fetch(ok);
        bus.FetchAck = 1'b1;
        @(negedge clk);
        bus.FetchAck = 1'b0;
        check("pre_reset_pc", bus.PCOut, 64'd28);
        check("pre_reset_count", 64'(bus.count), 64'd7);
        rst_n = 1'b0;
        @(negedge clk);
        check("midexec_reset_pc", bus.PCOut, 64'h0);
        check("midexec_reset_count", 64'(bus.count), 64'h0);
        check("midexec_reset_fetchreq", 64'(bus.FetchReq), 64'h0);
        check("midexec_reset_halted", 64'(bus.Halted), 64'h0);

        // Randomized instruction stream against the reference model.
        do_reset();
        bus.Run = 1'b1;
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                off = {$urandom, $urandom};
            end else begin
                s   = int'($urandom_range(0, 64)) - 32;
                off = 64'(longint'(s));
            end
            run_instr($urandom_range(0, 5), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), off);
            if ($urandom_range(0, 7) == 0) begin
                bus.Run = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                bus.Run = 1'b1;
            end
        end
        bus.Run = 1'b0;
        repeat (3) @(negedge clk);
        check("random_final_count", 64'(bus.count), 64'(m_cnt));
        check("scoreboard_drained", 64'(exp_q.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Closed-loop program-counter sequencer that drives the 64-bit PC into `CPU_Module`'s `PCIn` and owns the fetch/execute/update cycle. It issues instruction-fetch requests with a req/ack handshake, waits for the datapath to finish each instruction, and computes the next PC (sequential, conditional `CBZ`-style on `Zero`, or unconditional). It also keeps the 32-bit retired-instruction count and halts on request or on a fetch timeout.

## Interface
Parameters:
- `PC_WIDTH`, 64, PC and offset width.
- `RESET_PC`, 64'h0, PC value loaded on reset.
- `PC_STEP`, 4, sequential increment in bytes.
- `ACK_TIMEOUT`, 16, maximum cycles in FETCH without `FetchAck` before a fault; legal range 1..255.

Ports (one clock; reset is synchronous and active-low):
- `Clock`  in  1  rising-edge clock.
- `Reset_n`  in  1  synchronous, active-low reset.
- `Run`  in  1  start / continue stepping.
- `Halt`  in  1  stop request.
- `FetchAck`  in  1  instruction memory accepted the fetch for `PCOut`.
- `ExecDone`  in  1  datapath finished the current instruction.
- `Branch`  in  1  conditional branch; taken when `Zero`=1.
- `Uncond`  in  1  unconditional branch.
- `Zero`  in  1  ALU zero flag from `CPU_Module`.
- `BranchOffset`  in  PC_WIDTH  sign-extended word offset.
- `PCOut`  out  PC_WIDTH  current PC; connects to `PCIn`.
- `FetchReq`  out  1  fetch request.
- `count`  out  32  retired instructions.
- `Halted`  out  1  in HALT state.
- `Fault`  out  1  halt caused by fetch timeout.

## Operation
- States: IDLE, FETCH, EXEC, UPDATE, HALT.
- Reset values: state IDLE, `PCOut`=`RESET_PC`, `FetchReq`=0, `count`=0, `Halted`=0, `Fault`=0, timeout counter=0.
- IDLE: if `Halt`, go to HALT. Otherwise, if `Run`, go to FETCH.
- FETCH: `FetchReq`=1 and `PCOut` is held stable.
  - `FetchAck` → EXEC, timeout counter cleared.
  - Otherwise the counter increments. When it reaches `ACK_TIMEOUT`, go to HALT with `Fault`=1.
- EXEC: `ExecDone` → UPDATE. `Branch`, `Uncond`, `Zero` and `BranchOffset` are sampled on the cycle `ExecDone`=1.
- UPDATE computes the next PC:
  - `Uncond`=1: `PCOut + (BranchOffset<<2)`.
  - `Branch`=1 and `Zero`=1: `PCOut + (BranchOffset<<2)`.
  - Otherwise: `PCOut + PC_STEP`.
  - Arithmetic is modulo 2^PC_WIDTH (wraps silently).
  - `count` increments, modulo 2^32.
  - Next state is FETCH if `Run`, else IDLE.
- Priority: `Uncond` wins over `Branch`. A negative offset branches backward; an offset of 0 is a legal self-loop.
- `Halt` in IDLE, FETCH or EXEC → HALT on the next edge. The instruction is not retired and `PCOut`/`count` are unchanged.
- `Halt` during UPDATE: the update completes (PC and count written), then the block goes to HALT.
- HALT: `Halted`=1 and `FetchReq`=0. The only exit is reset.
- `Reset_n`=0 in any state restores all reset values on that edge. An in-flight fetch is abandoned.

## Timing
- All outputs are registered. `FetchReq` and `Halted` are decoded from the state register.
- Minimum is 3 cycles per instruction: FETCH with same-cycle ack, EXEC with `ExecDone`=1 on its first cycle, then UPDATE.
- `PCOut` changes only on the edge leaving UPDATE or on reset. It is stable for the whole of FETCH and EXEC.
- `FetchAck` is ignored outside FETCH. `ExecDone` is ignored outside EXEC.
- A timeout fault is taken on the edge where the counter equals `ACK_TIMEOUT`. With the default, that is 16 cycles with `FetchReq`=1 and no ack, giving HALT on the 17th edge.

## Structure
- Shared package `cpu_pkg` holds:
  - the state enum `seq_state_t`;
  - `PC_STEP_DEFAULT`;
  - `PC_WIDTH_DEFAULT`.
- One sub-module, `pc_next_calc`, is combinational. Inputs are PC, offset, `Branch`, `Uncond` and `Zero`; output is the next PC. It is unit-testable alone.

## Test plan
- Reset with `Run`=1, immediate ack and `ExecDone` for 4 instructions → `PCOut` steps 0,4,8,12,16; `count`=4; 3 cycles per instruction.
- At PC=8, `Branch`=1, `Zero`=1, offset=-2 → `PCOut`=0. Same stimulus with `Zero`=0 → `PCOut`=12.
- `Uncond`=1 and `Branch`=1 together, offset=5, PC=0 → `PCOut`=20. At PC=64'hFFFF_FFFF_FFFF_FFFC, a sequential step → `PCOut`=0.
- `FetchAck` held low in FETCH → after 16 request cycles, `Halted`=1, `Fault`=1, `FetchReq`=0. Only reset clears them.
- `Halt` in EXEC → `count` unchanged. `Halt` in UPDATE → `count`+1, then `Halted`=1.
- `Reset_n` low mid-EXEC with `count`=7, PC=28 → next edge `PCOut`=0, `count`=0, state IDLE.
